// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel write master: master FSM encoding,
// frame-buffer defaults and the FIFO entry layout.
package pixel_pkg;

    localparam int unsigned PIX_ENTRY_W      = 48;
    localparam logic [31:0] FB_BASE_DEFAULT  = 32'h0800_0000;
    localparam int unsigned FB_BYTES_DEFAULT = 153600;  // 320 x 240 x 2

    typedef enum logic {
        M_IDLE  = 1'b0,
        M_WRITE = 1'b1
    } mstate_t;

    // One buffered pixel: halfword-aligned byte address plus RGB565 colour.
    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] color;
    } pix_entry_t;

    // Builds a FIFO entry, forcing address bit 0 low so every write is
    // halfword aligned.
    function automatic pix_entry_t make_entry(input logic [31:0] addr,
                                              input logic [15:0] color);
        pix_entry_t e;
        e.addr  = {addr[31:1], 1'b0};
        e.color = color;
        return e;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding pending pixels between the request handshake and
// the Avalon master. DEPTH must be a power of two so pointers wrap naturally.
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [PIX_ENTRY_W-1:0]   wdata_i,
    input  logic                     pop_i,
    output logic [PIX_ENTRY_W-1:0]   rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [PIX_ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW:0]            count_q;
    logic                   do_push;
    logic                   do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array: written on push only.
    // NOTE: the data array is deliberately left out of reset; pointers and
    // count define validity, and a resettable array costs a reset net per bit.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking; push and pop together leave count alone.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_master.sv
// Pixel write master: accepts Draw requests from the line-drawing circuit,
// buffers them in pixel_fifo and drains them to the frame buffer through an
// Avalon-MM write-only master that honours waitrequest.
// Optional build macro PIXEL_CLIP_EN: acknowledge but drop pixels whose
// aligned address falls outside the frame buffer, counting them in Clip_Count.
module pixel_write_master
    import pixel_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] FB_BASE    = FB_BASE_DEFAULT,
    parameter int unsigned FB_BYTES   = FB_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Draw,
    input  logic [31:0] Pixel_Address,
    input  logic [15:0] Color,
    output logic        Write_Finish,
    output logic        Idle,
    output logic [15:0] Clip_Count,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [15:0] avm_writedata,
    output logic [1:0]  avm_byteenable,
    input  logic        avm_waitrequest
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic        guard_q;
    logic        accept;
    logic        push;
    logic        pop;
    pix_entry_t  in_entry;
    pix_entry_t  head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;

    mstate_t     state_q;
    logic [31:0] addr_q;
    logic [15:0] data_q;
    logic        write_q;

    // guard_q blocks an accept in the cycle right after one, so a Draw still
    // held while Write_Finish propagates is never taken twice.
    assign accept       = Draw && !fifo_full && !guard_q;
    assign Write_Finish = accept;
    assign in_entry     = make_entry(Pixel_Address, Color);

`ifdef PIXEL_CLIP_EN
    logic        in_range;
    logic [15:0] clip_cnt_q;

    // Widened to 33 bits so FB_BASE + FB_BYTES cannot wrap.
    assign in_range = ({1'b0, in_entry.addr} >= {1'b0, FB_BASE}) &&
                      ({1'b0, in_entry.addr} <  ({1'b0, FB_BASE} + 33'(FB_BYTES)));
    assign push       = accept && in_range;
    assign Clip_Count = clip_cnt_q;

    // Saturating count of acknowledged-but-dropped pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_cnt_q <= '0;
        end else if (accept && !in_range && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_q <= clip_cnt_q + 16'd1;
        end
    end
`else
    assign push       = accept;
    assign Clip_Count = 16'h0000;
`endif

    // Pop decision: refill from idle, or chain the next entry on the cycle the
    // current write completes so back-to-back writes have no bubble.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            M_IDLE:  pop = !fifo_empty;
            M_WRITE: pop = !avm_waitrequest && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    // Accept guard: remembers whether the previous cycle accepted.
    always_ff @(posedge clk) begin
        if (reset) guard_q <= 1'b0;
        else       guard_q <= accept;
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (in_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Master FSM with registered Avalon outputs held stable under waitrequest.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= M_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                M_IDLE: begin
                    if (!fifo_empty) begin
                        addr_q  <= head.addr;
                        data_q  <= head.color;
                        write_q <= 1'b1;
                        state_q <= M_WRITE;
                    end
                end
                M_WRITE: begin
                    if (!avm_waitrequest) begin
                        if (!fifo_empty) begin
                            addr_q <= head.addr;
                            data_q <= head.color;
                        end else begin
                            write_q <= 1'b0;
                            state_q <= M_IDLE;
                        end
                    end
                end
                default: begin
                    write_q <= 1'b0;
                    state_q <= M_IDLE;
                end
            endcase
        end
    end

    assign avm_address    = addr_q;
    assign avm_writedata  = data_q;
    assign avm_write      = write_q;
    assign avm_byteenable = 2'b11;

    // Idle only when nothing is queued, nothing is on the bus and no pixel is
    // being accepted this cycle.
    assign Idle = (fifo_count == '0) && (state_q == M_IDLE) && !accept;

endmodule
